// File: rtl/loader_pkg.sv
// Shared types and constants for the serial instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int unsigned OSR = 16;
  localparam int unsigned MID = 8;

  // Oversample tick divisor, truncated; never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OSR);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; pulses byte_valid or frame_err
// for one cycle per received frame.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DW  = $clog2(DIV + 1);

  rx_state_t     state, state_d;
  logic          rx_s1, rx_s2, rx_prev;
  logic [DW-1:0] div_cnt, div_d;
  logic [3:0]    os_cnt, os_d;
  logic [2:0]    bit_cnt, bit_d;
  logic [7:0]    shreg, sh_d;
  logic          valid_d, ferr_d;
  logic          tick;

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign byte_data = shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    os_d    = os_cnt;
    bit_d   = bit_cnt;
    sh_d    = shreg;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    div_d   = tick ? '0 : div_cnt + DW'(1);
    case (state)
      RX_IDLE: begin
        // Falling edge realigns the tick phase to the start bit.
        if (rx_prev && !rx_s2) begin
          state_d = RX_START;
          os_d    = '0;
          div_d   = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (os_cnt == 4'(MID - 1)) begin
            os_d    = '0;
            bit_d   = '0;
            state_d = rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            os_d = os_cnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (os_cnt == 4'(OSR - 1)) begin
            os_d  = '0;
            sh_d  = {rx_s2, shreg[7:1]};
            bit_d = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_d = RX_STOP;
          end else begin
            os_d = os_cnt + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (os_cnt == 4'(OSR - 1)) begin
            os_d    = '0;
            valid_d = rx_s2;
            ferr_d  = !rx_s2;
            state_d = RX_IDLE;
          end else begin
            os_d = os_cnt + 4'd1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      div_cnt    <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      div_cnt    <= div_d;
      os_cnt     <= os_d;
      bit_cnt    <= bit_d;
      shreg      <= sh_d;
      byte_valid <= valid_d;
      frame_err  <= ferr_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Serial boot loader: receives a count byte plus N big-endian words over UART
// and writes them to instruction memory while holding the CPU in reset.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115_200,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  input  logic                     start,
  output logic                     imem_we,
  output logic [$clog2(DEPTH)-1:0] imem_addr,
  output logic [31:0]              imem_din,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  state_t        state, state_d;
  logic          byte_valid, frame_err;
  logic [7:0]    byte_data;
  logic [7:0]    word_count, word_count_d;
  logic [CW-1:0] addr, addr_d;
  logic [1:0]    byte_idx, byte_idx_d;
  logic [31:0]   word, word_d;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign imem_addr = addr[AW-1:0];
  assign imem_din  = word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d      = state;
    word_count_d = word_count;
    addr_d       = addr;
    byte_idx_d   = byte_idx;
    word_d       = word;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_COUNT;
          addr_d  = '0;
        end
      end
      ST_COUNT: begin
        if (frame_err) begin
          state_d = ST_ERROR;
        end else if (byte_valid) begin
          word_count_d = byte_data;
          byte_idx_d   = '0;
          if (byte_data == 8'd0 || 32'(byte_data) > DEPTH) state_d = ST_ERROR;
          else                                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (frame_err) begin
          state_d = ST_ERROR;
        end else if (byte_valid) begin
          word_d     = {word[23:0], byte_data};
          byte_idx_d = byte_idx + 2'd1;
          if (byte_idx == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr + CW'(1);
        state_d = (addr + CW'(1) == CW'(word_count)) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered decodes of the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
      addr       <= '0;
      byte_idx   <= '0;
      word       <= '0;
      imem_we    <= 1'b0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      word_count <= word_count_d;
      addr       <= addr_d;
      byte_idx   <= byte_idx_d;
      word       <= word_d;
      imem_we    <= (state_d == ST_WRITE);
      busy       <= state_d inside {ST_COUNT, ST_DATA, ST_WRITE};
      cpu_hold   <= state_d inside {ST_COUNT, ST_DATA, ST_WRITE, ST_ERROR};
      done       <= (state_d == ST_DONE);
      err        <= (state_d == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: serial frames against a
// frame-level reference model of the expected memory writes and status.
module tb_instr_loader;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DEPTH  = 32;

  logic        clk = 1'b0;
  logic        reset, rx, start;
  logic        imem_we, cpu_hold, busy, done, err;
  logic [4:0]  imem_addr;
  logic [31:0] imem_din;

  always #5 clk = ~clk;

  instr_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .start     (start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int          tests  = 0;
  int          failed = 0;
  longint      cyc    = 0;
  longint      last_we = -1;
  longint      hold_fall = -1;
  logic        prev_hold = 1'b0;
  logic [7:0]  bq[$];
  logic [4:0]  obs_a[$];
  logic [31:0] obs_d[$];

  always @(posedge clk) cyc++;

  // Write capture and cpu_hold release timing
  always @(negedge clk) begin
    if (imem_we) begin
      obs_a.push_back(imem_addr);
      obs_d.push_back(imem_din);
      last_we = cyc;
    end
    if (prev_hold && !cpu_hold) hold_fall = cyc;
    prev_hold = cpu_hold;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":we"},   32'(imem_we),   0);
    check({tag, ":addr"}, 32'(imem_addr), 0);
    check({tag, ":din"},  imem_din,       0);
    check({tag, ":hold"}, 32'(cpu_hold),  0);
    check({tag, ":busy"}, 32'(busy),      0);
    check({tag, ":done"}, 32'(done),      0);
    check({tag, ":err"},  32'(err),       0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    rx = stop;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (16) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] w);
    bq.push_back(w[31:24]);
    bq.push_back(w[23:16]);
    bq.push_back(w[15:8]);
    bq.push_back(w[7:0]);
  endtask

  task automatic build_random(input logic [7:0] n);
    bq.delete();
    bq.push_back(n);
    for (int i = 0; i < int'(n); i++) push_word($urandom);
  endtask

  // Sends bq as one load; indices select a bad stop bit, a stray start
  // pulse or an rx glitch before the given byte (-1 = none).
  task automatic run_frame(input int bad_idx, input int start_idx, input int glitch_idx,
                           input string tag);
    int          n, nb;
    bit          fin, exp_err, exp_done;
    logic [31:0] w;
    logic [31:0] exp_d[$];
    obs_a.delete();
    obs_d.delete();
    pulse_start();
    check({tag, ":busy_armed"}, 32'(busy), 1);
    check({tag, ":hold_armed"}, 32'(cpu_hold), 1);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == glitch_idx) begin
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
      end
      if (i == start_idx) pulse_start();
      send_byte(bq[i], i != bad_idx);
    end
    repeat (24) @(negedge clk);

    exp_err = 0; exp_done = 0; fin = 0; n = 0; nb = 0; w = '0;
    for (int i = 0; i < bq.size() && !fin; i++) begin
      if (i == bad_idx) begin
        exp_err = 1; fin = 1;
      end else if (i == 0) begin
        n = int'(bq[0]);
        if (n < 1 || n > int'(DEPTH)) begin exp_err = 1; fin = 1; end
      end else begin
        w = (w << 8) | 32'(bq[i]);
        nb++;
        if (nb % 4 == 0) begin
          exp_d.push_back(w);
          if (exp_d.size() == n) begin exp_done = 1; fin = 1; end
        end
      end
    end

    check({tag, ":nwrites"}, 32'(obs_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      check($sformatf("%s:addr%0d", tag, i), 32'(obs_a[i]), 32'(i));
      check($sformatf("%s:data%0d", tag, i), obs_d[i], exp_d[i]);
    end
    check({tag, ":done"}, 32'(done), 32'(exp_done));
    check({tag, ":err"},  32'(err),  32'(exp_err));
    check({tag, ":busy"}, 32'(busy), 32'(!exp_done && !exp_err));
    check({tag, ":hold"}, 32'(cpu_hold), 32'(!exp_done));
    if (exp_done) check({tag, ":hold_gap"}, 32'(hold_fall - last_we), 1);
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("post_reset");

    // Reference program
    bq.delete();
    bq.push_back(8'h02);
    push_word(32'h2001_0005);
    push_word(32'hAC01_0000);
    run_frame(-1, -1, -1, "normal");
    check("normal:w0_const", (obs_d.size() > 0) ? obs_d[0] : 32'hDEAD_BEEF, 32'h2001_0005);
    check("normal:w1_const", (obs_d.size() > 1) ? obs_d[1] : 32'hDEAD_BEEF, 32'hAC01_0000);

    // Framing error on the first data byte
    bq.delete();
    bq.push_back(8'h01);
    push_word($urandom);
    run_frame(1, -1, -1, "frame_err");

    // Illegal counts
    bq.delete();
    bq.push_back(8'h00);
    run_frame(-1, -1, -1, "count0");
    bq.delete();
    bq.push_back(8'h21);
    push_word($urandom);
    run_frame(-1, -1, -1, "count33");

    // Full depth
    build_random(8'h20);
    run_frame(-1, -1, -1, "full");

    // Random small loads
    for (int r = 0; r < 4; r++) begin
      build_random(8'($urandom_range(1, 4)));
      run_frame(-1, -1, -1, $sformatf("rand%0d", r));
    end

    // Glitches before the count byte and mid-word
    build_random(8'd2);
    run_frame(-1, -1, 0, "glitch_cnt");
    build_random(8'd2);
    run_frame(-1, -1, 6, "glitch_mid");

    // Stray start mid-word
    build_random(8'd3);
    run_frame(-1, 7, -1, "start_mid");

    // Reset after 6 bytes of a 3-word load
    build_random(8'd3);
    obs_a.delete();
    obs_d.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b1);
    check("rst_mid:prior_writes", 32'(obs_d.size()), 1);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    build_random(8'd3);
    run_frame(-1, -1, -1, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
